// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (1280x1024 @ 60 Hz, 108 MHz pixel clock)
// and the coordinate type used by the timing generator and its counters.
package vga_pkg;

   typedef logic [11:0] coord_t;

   localparam int DEF_H_ACTIVE = 1280;
   localparam int DEF_H_FP     = 48;
   localparam int DEF_H_SYNC   = 112;
   localparam int DEF_H_BP     = 248;
   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

   localparam int DEF_V_ACTIVE = 1024;
   localparam int DEF_V_FP     = 1;
   localparam int DEF_V_SYNC   = 3;
   localparam int DEF_V_BP     = 38;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_sync_counter.sv
// Wrap-at-MAX counter with a carry that is high on the enabled cycle that wraps,
// so a cascaded counter advances on the same edge this one returns to zero.
module vga_sync_counter
   import vga_pkg::*;
#(
   parameter coord_t MAX = coord_t'(DEF_H_TOTAL - 1)
)(
   input  logic   i_clk,
   input  logic   i_reset,
   input  logic   i_en,
   output coord_t o_count,
   output logic   o_carry
);

   coord_t r_count;

   assign o_carry = i_en && (r_count == MAX);
   assign o_count = r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= o_carry ? '0 : r_count + coord_t'(1);
      end
   end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: coordinates, blanked colour and active-high syncs aligned one clock behind them.
// Optional build macro VGA_TESTPAT_EN adds an 8-bar colour test pattern selected by test_sel.
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
)(
   input  logic        clk_vga,
   input  logic        reset,
   input  logic [3:0]  VGA_Red_Grid,
   input  logic [3:0]  VGA_Green_Grid,
   input  logic [3:0]  VGA_Blue_Grid,
   input  logic        test_sel,
   output logic [11:0] VGA_HORZ_COORD,
   output logic [11:0] VGA_VERT_COORD,
   output logic [3:0]  VGA_RED,
   output logic [3:0]  VGA_GREEN,
   output logic [3:0]  VGA_BLUE,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        frame_start
);

   localparam coord_t H_MAX    = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam coord_t V_MAX    = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
   localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
   localparam coord_t H_HS_BEG = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t H_HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam coord_t V_VS_BEG = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t V_VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

   coord_t     w_h_cnt;
   coord_t     w_v_cnt;
   logic       w_h_wrap;
   logic       w_v_wrap;
   logic       w_active;
   logic [3:0] w_red;
   logic [3:0] w_green;
   logic [3:0] w_blue;

   logic [3:0] r_red;
   logic [3:0] r_green;
   logic [3:0] r_blue;
   logic       r_hs;
   logic       r_vs;
   logic       r_fs_arm;

   vga_sync_counter #(.MAX(H_MAX)) u_h_cnt (
      .i_clk   (clk_vga),
      .i_reset (reset),
      .i_en    (1'b1),
      .o_count (w_h_cnt),
      .o_carry (w_h_wrap)
   );

   vga_sync_counter #(.MAX(V_MAX)) u_v_cnt (
      .i_clk   (clk_vga),
      .i_reset (reset),
      .i_en    (w_h_wrap),
      .o_count (w_v_cnt),
      .o_carry (w_v_wrap)
   );

   assign w_active = (w_h_cnt < H_ACT) && (w_v_cnt < V_ACT);

`ifdef VGA_TESTPAT_EN
   localparam coord_t BAR_W = coord_t'(H_ACTIVE / 8);

   logic [2:0] w_bar;
   assign w_bar = 3'(w_h_cnt / BAR_W);

   // Bar order white..black maps each component to one inverted index bit.
   always_comb begin
      w_red   = VGA_Red_Grid;
      w_green = VGA_Green_Grid;
      w_blue  = VGA_Blue_Grid;
      if (test_sel) begin
         w_red   = {4{~w_bar[1]}};
         w_green = {4{~w_bar[2]}};
         w_blue  = {4{~w_bar[0]}};
      end
   end
`else
   logic w_unused_test_sel;
   assign w_unused_test_sel = test_sel;
   assign w_red   = VGA_Red_Grid;
   assign w_green = VGA_Green_Grid;
   assign w_blue  = VGA_Blue_Grid;
`endif

   // Colour and syncs are decoded from this cycle's coordinates and land one clock later.
   // r_fs_arm marks "the coming cycle is (0,0)", which reset also guarantees.
   always_ff @(posedge clk_vga) begin
      if (reset) begin
         r_red    <= 4'h0;
         r_green  <= 4'h0;
         r_blue   <= 4'h0;
         r_hs     <= 1'b0;
         r_vs     <= 1'b0;
         r_fs_arm <= 1'b1;
      end else begin
         r_red    <= w_active ? w_red   : 4'h0;
         r_green  <= w_active ? w_green : 4'h0;
         r_blue   <= w_active ? w_blue  : 4'h0;
         r_hs     <= (w_h_cnt >= H_HS_BEG) && (w_h_cnt <= H_HS_END);
         r_vs     <= (w_v_cnt >= V_VS_BEG) && (w_v_cnt <= V_VS_END);
         r_fs_arm <= w_v_wrap;
      end
   end

   assign VGA_HORZ_COORD = w_h_cnt;
   assign VGA_VERT_COORD = w_v_cnt;
   assign VGA_RED        = r_red;
   assign VGA_GREEN      = r_green;
   assign VGA_BLUE       = r_blue;
   assign VGA_HS         = r_hs;
   assign VGA_VS         = r_vs;
   assign frame_start    = r_fs_arm && !reset;

endmodule
